// File: rtl/sub_pkg.sv
// Shared defaults and result payload type for the pipelined subtractor.
// SUB_RES_T(W) builds the width-specific payload struct inside parameterized modules.
`ifndef SUB_PKG_SV
`define SUB_PKG_SV

`define SUB_RES_T(W) struct packed { logic bo; logic [(W)-1:0] diff; }

package sub_pkg;

   localparam int unsigned DEF_WIDTH   = 4;
   localparam int unsigned DEF_LATENCY = 3;

   typedef `SUB_RES_T(DEF_WIDTH) sub_res_t;

endpackage

`endif

// File: rtl/sub_stage.sv
// One pipeline register: valid bit plus result payload, advancing only when enabled.
module sub_stage #(
   parameter type T = sub_pkg::sub_res_t
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic valid_d,
   input  T     data_d,
   output logic valid_q,
   output T     data_q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (en) begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/subtractor_pipe_t.sv
// WIDTH-bit subtractor with borrow in/out, carried through LATENCY registered stages
// under a global valid/ready stall; the result is computed before stage 0.
module subtractor_pipe_t
   import sub_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned LATENCY = DEF_LATENCY
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bi,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bo
);

   localparam int unsigned LAST = LATENCY - 1;

   typedef `SUB_RES_T(WIDTH) res_t;

   logic           stall;
   logic           en;
   logic [WIDTH:0] full;
   res_t           res_in;
   logic           valid_s [LATENCY];
   res_t           data_s  [LATENCY];

   // Payload is zeroed for bubbles so idle operand values never enter the pipe.
   always_comb begin
      full   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
      res_in = '0;
      if (in_valid) begin
         res_in.bo   = full[WIDTH];
         res_in.diff = full[WIDTH-1:0];
      end
   end

   // Whole pipe freezes while the head result is waiting; no bubble squeezing.
   assign stall    = out_valid && !out_ready;
   assign en       = !stall;
   assign in_ready = !stall;

   for (genvar k = 0; k < LATENCY; k++) begin : g_stage
      if (k == 0) begin : g_first
         sub_stage #(.T(res_t)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .valid_d (in_valid),
            .data_d  (res_in),
            .valid_q (valid_s[k]),
            .data_q  (data_s[k])
         );
      end else begin : g_next
         sub_stage #(.T(res_t)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .valid_d (valid_s[k-1]),
            .data_d  (data_s[k-1]),
            .valid_q (valid_s[k]),
            .data_q  (data_s[k])
         );
      end
   end

   assign out_valid = valid_s[LAST];
   assign diff      = data_s[LAST].diff;
   assign bo        = data_s[LAST].bo;

endmodule
